pc_redirect_unit: RTL and testbench
===================================

Name: pc_redirect_unit

Overview:
- Fetch-stage program-counter owner. Consumes redirect targets from the jump calculator (J/JAL), the register-jump path (JR) and branch resolution, and sequences the PC.
- Supplies PC+4 and its upper nibble back to the jump calculator, and drives the IF/ID flush.
- Buffers a redirect that arrives while fetch is stalled, so no redirect is lost.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of the applied-redirect counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- stall_i  input  1  hazard-unit fetch stall; PC holds while high.
- branch_i  input  1  taken branch this cycle.
- branch_addr_i  input  32  branch target.
- jr_i  input  1  JR this cycle.
- jr_addr_i  input  32  register target.
- jump_i  input  1  J/JAL this cycle.
- jump_addr_i  input  32  target from the jump calculator.
- pc_o  output  32  current fetch PC.
- pcplus4_o  output  32  pc_o + 4 (combinational).
- pc_upper4_o  output  4  pcplus4_o[31:28], fed to the jump calculator.
- flush_ifid_o  output  1  squash the IF/ID register at this edge.
- redirect_pending_o  output  1  buffered redirect awaiting un-stall.
- misaligned_o  output  1  sticky: a target had bits [1:0] != 0.
- redirect_cnt_o  output  CNT_W  saturating count of applied redirects.

Behaviour:
- Reset (async, rst_n low): pc_o=RESET_PC; pending_valid=0; pending_addr=0; misaligned_o=0; redirect_cnt_o=0. Outputs are valid immediately. Release is synchronous to clk.
- Request select, same cycle, fixed priority: branch_i > jr_i > jump_i. req = any of the three. req_addr = selected target with bits [1:0] forced to 00.
- apply = ~stall_i & (req | pending_valid). Target = req ? req_addr : pending_addr. A new request beats a pending one.
- Next-PC rules at each clk edge:
  - stall_i=1: PC holds.
  - apply: pc_o <= target.
  - else: pc_o <= pc_o + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- flush_ifid_o = apply (combinational). High exactly in cycles where the PC takes a redirect; low during stall, including while a redirect is pending.
- Pending buffer:
  - stall_i & req: pending_addr <= req_addr, pending_valid <= 1. A later request during the same stall overwrites (latest wins).
  - apply: pending_valid <= 0.
  - redirect_pending_o = pending_valid.
- Latency: an unstalled request redirects at the next edge. A stalled request redirects at the first edge with stall_i=0.
- misaligned_o: set on the edge where any selected req has req target[1:0] != 0, regardless of stall. Cleared only by reset.
- redirect_cnt_o: +1 on each apply edge; saturates at all-ones.
- Reset mid-stall with a pending redirect: the buffer is discarded and PC = RESET_PC.
- Unselected lower-priority targets in the same cycle are ignored and are not counted.

Test Plan:
- Reset with RESET_PC=32'h0040_0000, no stall → pc_o = 0x400000, 0x400004, 0x400008; pc_upper4_o=0; flush_ifid_o=0.
- At pc 0x400008 drive jump_i=1, jump_addr_i=0x0040_0100 → flush_ifid_o=1 that cycle; next pc_o=0x400100; redirect_cnt_o=1.
- stall_i=1 for 3 cycles with branch_i pulse (target 0x0000_2000) in the first stall cycle:
  - pc_o holds and flush_ifid_o stays 0.
  - redirect_pending_o=1 from the next cycle.
  - First unstalled cycle: flush_ifid_o=1, then pc_o=0x2000 and pending clears.
- Same cycle branch_i (0x100), jr_i (0x200), jump_i (0x300) → pc_o=0x100; count +1 only.
- jr_addr_i=0x0000_1236 → pc_o=0x1234; misaligned_o=1 and stays 1 until rst_n pulse. Then pc_o=0xFFFF_FFFC free-runs to 0x0000_0000.
- Pending redirect present, assert rst_n=0 asynchronously mid-cycle → pc_o=RESET_PC immediately; redirect_pending_o=0; counter=0.

Source files
------------

// File: rtl/pc_redirect_if.sv
// Fetch-side redirect bus: redirect requests and stall in, fetch PC and status out.
interface pc_redirect_if #(
  parameter int CNT_W = 16
);
  logic             stall_i;
  logic             branch_i;
  logic [31:0]      branch_addr_i;
  logic             jr_i;
  logic [31:0]      jr_addr_i;
  logic             jump_i;
  logic [31:0]      jump_addr_i;
  logic [31:0]      pc_o;
  logic [31:0]      pcplus4_o;
  logic [3:0]       pc_upper4_o;
  logic             flush_ifid_o;
  logic             redirect_pending_o;
  logic             misaligned_o;
  logic [CNT_W-1:0] redirect_cnt_o;

  // Requests are single-cycle pulses sampled at every rising edge. There is no
  // ready back-pressure: a request that meets a stall is buffered in the unit,
  // so the producer never has to hold or repeat it.
  modport master (
    output stall_i, branch_i, branch_addr_i, jr_i, jr_addr_i, jump_i, jump_addr_i,
    input  pc_o, pcplus4_o, pc_upper4_o, flush_ifid_o, redirect_pending_o,
           misaligned_o, redirect_cnt_o
  );

  modport slave (
    input  stall_i, branch_i, branch_addr_i, jr_i, jr_addr_i, jump_i, jump_addr_i,
    output pc_o, pcplus4_o, pc_upper4_o, flush_ifid_o, redirect_pending_o,
           misaligned_o, redirect_cnt_o
  );
endinterface

// File: rtl/pc_redirect_unit.sv
// Fetch PC owner: selects branch/JR/jump redirects, buffers one across a stall,
// and drives the IF/ID flush plus sticky-misaligned and applied-redirect count.
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input logic          clk,
  input logic          rst_n,
  pc_redirect_if.slave bus
);

  logic [31:0]      pc_q;
  logic [31:0]      pending_addr_q;
  logic             pending_valid_q;
  logic             misaligned_q;
  logic [CNT_W-1:0] cnt_q;

  logic             req;
  logic [31:0]      req_raw;
  logic [31:0]      req_addr;
  logic             apply;
  logic [31:0]      target;

  // Fixed priority: branch over JR over jump.
  always_comb begin
    req_raw = 32'h0;
    if (bus.branch_i)    req_raw = bus.branch_addr_i;
    else if (bus.jr_i)   req_raw = bus.jr_addr_i;
    else if (bus.jump_i) req_raw = bus.jump_addr_i;
  end

  assign req      = bus.branch_i | bus.jr_i | bus.jump_i;
  assign req_addr = {req_raw[31:2], 2'b00};
  assign apply    = ~bus.stall_i & (req | pending_valid_q);
  // A fresh request supersedes whatever was buffered during the stall.
  assign target   = req ? req_addr : pending_addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q            <= RESET_PC;
      pending_addr_q  <= 32'h0;
      pending_valid_q <= 1'b0;
      misaligned_q    <= 1'b0;
      cnt_q           <= '0;
    end else begin
      if (req && (req_raw[1:0] != 2'b00)) begin
        misaligned_q <= 1'b1;
      end

      if (bus.stall_i) begin
        if (req) begin
          pending_addr_q  <= req_addr;
          pending_valid_q <= 1'b1;
        end
      end else if (apply) begin
        pc_q            <= target;
        pending_valid_q <= 1'b0;
        if (~&cnt_q) begin
          cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end else begin
        pc_q <= pc_q + 32'd4;
      end
    end
  end

  assign bus.pc_o               = pc_q;
  assign bus.pcplus4_o          = pc_q + 32'd4;
  assign bus.pc_upper4_o        = bus.pcplus4_o[31:28];
  assign bus.flush_ifid_o       = apply;
  assign bus.redirect_pending_o = pending_valid_q;
  assign bus.misaligned_o       = misaligned_q;
  assign bus.redirect_cnt_o     = cnt_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Bench for pc_redirect_unit: per-cycle reference model plus directed literal checks;
// a narrow-counter second instance exercises counter saturation.
module tb_pc_redirect_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  pc_redirect_if #(.CNT_W(16)) bus ();
  pc_redirect_if #(.CNT_W(3))  bus_s ();

  pc_redirect_unit #(.RESET_PC(RST_PC), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  pc_redirect_unit #(.RESET_PC(RST_PC), .CNT_W(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .bus(bus_s)
  );

  assign bus_s.stall_i       = bus.stall_i;
  assign bus_s.branch_i      = bus.branch_i;
  assign bus_s.branch_addr_i = bus.branch_addr_i;
  assign bus_s.jr_i          = bus.jr_i;
  assign bus_s.jr_addr_i     = bus.jr_addr_i;
  assign bus_s.jump_i        = bus.jump_i;
  assign bus_s.jump_addr_i   = bus.jump_addr_i;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_pc    = RST_PC;
  bit          m_pend  = 1'b0;
  logic [31:0] m_paddr = 32'h0;
  bit          m_mis   = 1'b0;
  int          m_cnt   = 0;

  function automatic bit any_req();
    return bus.branch_i || bus.jr_i || bus.jump_i;
  endfunction

  function automatic logic [31:0] chosen();
    if (bus.branch_i) return bus.branch_addr_i;
    if (bus.jr_i)     return bus.jr_addr_i;
    return bus.jump_addr_i;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = RST_PC; m_pend = 0; m_paddr = 0; m_mis = 0; m_cnt = 0;
    end else begin
      logic [31:0] t;
      bit have;
      have = any_req();
      t    = chosen();
      if (have && (t % 4 != 0)) m_mis = 1;
      if (bus.stall_i) begin
        if (have) begin m_pend = 1; m_paddr = t & ~32'h3; end
      end else if (have || m_pend) begin
        m_pc   = have ? (t & ~32'h3) : m_paddr;
        m_pend = 0;
        m_cnt++;
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      logic [31:0] p4;
      p4 = m_pc + 32'd4;
      check("pc",        bus.pc_o, m_pc);
      check("pcplus4",   bus.pcplus4_o, p4);
      check("upper4",    {28'h0, bus.pc_upper4_o}, {28'h0, p4[31:28]});
      check("flush",     {31'h0, bus.flush_ifid_o}, {31'h0, (!bus.stall_i && (any_req() || m_pend))});
      check("pending",   {31'h0, bus.redirect_pending_o}, {31'h0, m_pend});
      check("misalign",  {31'h0, bus.misaligned_o}, {31'h0, m_mis});
      check("cnt",       {16'h0, bus.redirect_cnt_o}, (m_cnt > 65535) ? 32'd65535 : 32'(m_cnt));
      check("cnt_sat",   {29'h0, bus_s.redirect_cnt_o}, (m_cnt > 7) ? 32'd7 : 32'(m_cnt));
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.branch_i = 0; bus.jr_i = 0; bus.jump_i = 0;
  endtask

  initial begin
    bus.stall_i = 0; clear_reqs();
    bus.branch_addr_i = 0; bus.jr_addr_i = 0; bus.jump_addr_i = 0;
    rst_n = 0;
    step(); chk_en = 1;
    step();
    rst_n = 1;

    // Free-running sequence from reset
    check("lit_pc0", bus.pc_o, 32'h0040_0000);
    check("lit_up0", {28'h0, bus.pc_upper4_o}, 32'h0);
    check("lit_fl0", {31'h0, bus.flush_ifid_o}, 32'h0);
    step(); check("lit_pc1", bus.pc_o, 32'h0040_0004);
    step(); check("lit_pc2", bus.pc_o, 32'h0040_0008);

    // Unstalled jump
    bus.jump_i = 1; bus.jump_addr_i = 32'h0040_0100;
    #1 check("lit_fl_jump", {31'h0, bus.flush_ifid_o}, 32'h1);
    step(); clear_reqs();
    check("lit_pc_jump", bus.pc_o, 32'h0040_0100);
    check("lit_cnt1", {16'h0, bus.redirect_cnt_o}, 32'd1);

    // Branch buffered across a 3-cycle stall
    bus.stall_i = 1; bus.branch_i = 1; bus.branch_addr_i = 32'h0000_2000;
    #1 check("lit_fl_stall", {31'h0, bus.flush_ifid_o}, 32'h0);
    step(); clear_reqs();
    check("lit_pend1", {31'h0, bus.redirect_pending_o}, 32'h1);
    check("lit_hold", bus.pc_o, 32'h0040_0100);
    step(); step();
    check("lit_hold3", bus.pc_o, 32'h0040_0100);
    bus.stall_i = 0;
    #1 check("lit_fl_unstall", {31'h0, bus.flush_ifid_o}, 32'h1);
    step();
    check("lit_pc_br", bus.pc_o, 32'h0000_2000);
    check("lit_pend0", {31'h0, bus.redirect_pending_o}, 32'h0);

    // Simultaneous requests: branch wins, counted once
    bus.branch_i = 1; bus.branch_addr_i = 32'h100;
    bus.jr_i = 1;     bus.jr_addr_i = 32'h200;
    bus.jump_i = 1;   bus.jump_addr_i = 32'h300;
    step(); clear_reqs();
    check("lit_pc_prio", bus.pc_o, 32'h100);
    check("lit_cnt3", {16'h0, bus.redirect_cnt_o}, 32'd3);

    // Misaligned JR target
    bus.jr_i = 1; bus.jr_addr_i = 32'h0000_1236;
    step(); clear_reqs();
    check("lit_pc_jr", bus.pc_o, 32'h0000_1234);
    check("lit_mis", {31'h0, bus.misaligned_o}, 32'h1);
    step();
    check("lit_pc_jr4", bus.pc_o, 32'h0000_1238);

    // Burst of jumps drives the narrow counter into saturation
    for (int i = 0; i < 8; i++) begin
      bus.jump_i = 1; bus.jump_addr_i = 32'h1000 + 32'(i) * 16;
      step();
    end
    clear_reqs();
    check("lit_cnt12", {16'h0, bus.redirect_cnt_o}, 32'd12);
    check("lit_sat", {29'h0, bus_s.redirect_cnt_o}, 32'd7);

    // Latest request during a stall wins
    bus.stall_i = 1;
    bus.jump_i = 1; bus.jump_addr_i = 32'h5000; step(); clear_reqs();
    bus.jr_i = 1;   bus.jr_addr_i = 32'h6000;   step(); clear_reqs();
    step();
    bus.stall_i = 0; step();
    check("lit_pc_latest", bus.pc_o, 32'h6000);

    // New request on the un-stall cycle beats the buffered one
    bus.stall_i = 1; bus.branch_i = 1; bus.branch_addr_i = 32'h7000; step(); clear_reqs();
    bus.stall_i = 0; bus.jump_i = 1; bus.jump_addr_i = 32'h8000; step(); clear_reqs();
    check("lit_pc_newwins", bus.pc_o, 32'h8000);
    check("lit_cnt14", {16'h0, bus.redirect_cnt_o}, 32'd14);

    // PC wrap at the top of the address space
    bus.jump_i = 1; bus.jump_addr_i = 32'hFFFF_FFFC; step(); clear_reqs();
    check("lit_pc_top", bus.pc_o, 32'hFFFF_FFFC);
    check("lit_p4_wrap", bus.pcplus4_o, 32'h0);
    step();
    check("lit_pc_wrap", bus.pc_o, 32'h0);
    check("lit_mis_sticky", {31'h0, bus.misaligned_o}, 32'h1);

    // Asynchronous reset while a redirect is pending
    bus.stall_i = 1; bus.branch_i = 1; bus.branch_addr_i = 32'h9000; step(); clear_reqs();
    check("lit_pend_pre", {31'h0, bus.redirect_pending_o}, 32'h1);
    #3 rst_n = 0;
    #1;
    check("lit_rst_pc", bus.pc_o, RST_PC);
    check("lit_rst_pend", {31'h0, bus.redirect_pending_o}, 32'h0);
    check("lit_rst_cnt", {16'h0, bus.redirect_cnt_o}, 32'h0);
    check("lit_rst_mis", {31'h0, bus.misaligned_o}, 32'h0);
    bus.stall_i = 0;
    step();
    rst_n = 1;
    step();
    check("lit_pc_after", bus.pc_o, 32'h0040_0004);
    step();

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
